// File: rtl/keylock_sequencer.sv
// keylock_sequencer: debounced button front end plus a sequencer that drives
// a keylock with active-low pulses, collects 5 digits, checks the result and
// enforces a lockout after repeated failures.
// Ports:
//   clock, in_reset_n                 clock, async active-low reset
//   in_acc_n, in_start_n, in_finish_n raw active-low buttons
//   in_key                            raw BCD digit switches
//   in_kl_closed, in_kl_error         keylock status
//   ou_kl_acc/start/finish, ou_kl_key active-low pulses and latched digit
//   ou_digit_count, ou_fail_count     progress counters
//   ou_busy, ou_locked_out            status levels
//   ou_bad_digit                      one-cycle pulse on a non-BCD digit
module keylock_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int RESULT_WAIT     = 4,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 64
) (
    input  logic       clock,
    input  logic       in_reset_n,
    input  logic       in_acc_n,
    input  logic       in_start_n,
    input  logic       in_finish_n,
    input  logic [3:0] in_key,
    input  logic       in_kl_closed,
    input  logic       in_kl_error,
    output logic       ou_kl_acc,
    output logic       ou_kl_start,
    output logic       ou_kl_finish,
    output logic [3:0] ou_kl_key,
    output logic [2:0] ou_digit_count,
    output logic [1:0] ou_fail_count,
    output logic       ou_busy,
    output logic       ou_locked_out,
    output logic       ou_bad_digit
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + PULSE_CYCLES + RESULT_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE, COLLECT, PULSE, WAIT_RESULT, LOCKOUT
    } state_t;

    typedef enum logic [1:0] {K_ACC, K_START, K_FIN} kind_t;

    // bit 0 = acc, bit 1 = start, bit 2 = finish
    logic [2:0]         raw;
    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [2:0]         deb;
    logic [2:0]         deb_d;
    logic [2:0]         press;
    logic [2:0][CW-1:0] cnt;

    assign raw = {in_finish_n, in_start_n, in_acc_n};

    // The count restarts whenever the sample agrees with the debounced level,
    // so only an unbroken run of disagreeing samples flips it.
    always_ff @(posedge clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press = deb_d & ~deb;

    logic fin_ev;
    logic acc_ev;
    logic start_ev;

    assign fin_ev   = press[2];
    assign acc_ev   = press[0] & ~press[2];
    assign start_ev = press[1] & ~press[0] & ~press[2];

    state_t        state;
    state_t        state_nx;
    kind_t         kind;
    kind_t         kind_nx;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nx;
    logic          res_now;
    logic          key_ok;
    logic          full;
    logic          fail_hit;
    logic [1:0]    fail_inc;

    assign key_ok   = (in_key <= 4'd9);
    assign full     = (ou_digit_count == 3'd5);
    assign fail_inc = (ou_fail_count == 2'(MAX_FAILS)) ?
                      ou_fail_count : ou_fail_count + 2'd1;
    assign fail_hit = in_kl_error && (fail_inc == 2'(MAX_FAILS));

    always_ff @(posedge clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state <= IDLE;
            kind  <= K_ACC;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
            tmr   <= tmr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        tmr_nx   = tmr + TW'(1);
        res_now  = 1'b0;
        unique case (state)
            IDLE, COLLECT: begin
                tmr_nx = '0;
                if (fin_ev) begin
                    if (full) begin
                        state_nx = PULSE;
                        kind_nx  = K_FIN;
                    end
                end else if (acc_ev) begin
                    if (key_ok && !full) begin
                        state_nx = PULSE;
                        kind_nx  = K_ACC;
                    end
                end else if (start_ev && state == IDLE && !in_kl_closed) begin
                    state_nx = PULSE;
                    kind_nx  = K_START;
                end
            end
            PULSE: begin
                if (tmr == TW'(PULSE_CYCLES - 1)) begin
                    tmr_nx = '0;
                    unique case (kind)
                        K_ACC:   state_nx = COLLECT;
                        K_FIN:   state_nx = WAIT_RESULT;
                        default: state_nx = IDLE;
                    endcase
                end
            end
            WAIT_RESULT: begin
                if (tmr == TW'(RESULT_WAIT - 1)) begin
                    tmr_nx   = '0;
                    res_now  = 1'b1;
                    state_nx = fail_hit ? LOCKOUT : IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr == TW'(LOCKOUT_CYCLES - 1)) begin
                    tmr_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ou_busy       = (state == PULSE) || (state == WAIT_RESULT) ||
                        (state == LOCKOUT);
        ou_locked_out = (state == LOCKOUT);
    end

    // Pulse lines are flops loaded from the next state, so each is low
    // exactly while the FSM sits in PULSE for its kind.
    logic go_pulse;
    logic collecting;

    assign go_pulse   = (state_nx == PULSE);
    assign collecting = (state == IDLE) || (state == COLLECT);

    always_ff @(posedge clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            ou_kl_acc      <= 1'b1;
            ou_kl_start    <= 1'b1;
            ou_kl_finish   <= 1'b1;
            ou_kl_key      <= '0;
            ou_digit_count <= '0;
            ou_fail_count  <= '0;
            ou_bad_digit   <= 1'b0;
        end else begin
            ou_kl_acc    <= !(go_pulse && kind_nx == K_ACC);
            ou_kl_start  <= !(go_pulse && kind_nx == K_START);
            ou_kl_finish <= !(go_pulse && kind_nx == K_FIN);
            ou_bad_digit <= collecting && acc_ev && !key_ok;
            if (collecting && go_pulse && kind_nx == K_ACC) begin
                ou_kl_key      <= in_key;
                ou_digit_count <= ou_digit_count + 3'd1;
            end
            if (res_now) begin
                ou_digit_count <= '0;
                ou_fail_count  <= in_kl_error ? fail_inc : 2'd0;
            end
            if (state == LOCKOUT && state_nx == IDLE) begin
                ou_fail_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keylock_sequencer.sv
// tb_keylock_sequencer: directed and randomized button sequences checked
// against a transaction-level model of the keylock rules.
module tb_keylock_sequencer;
    localparam int PW = 2;
    localparam int LK = 64;
    localparam int MF = 3;

    logic       clock = 1'b0;
    logic       in_reset_n = 1'b1;
    logic       in_acc_n = 1'b1;
    logic       in_start_n = 1'b1;
    logic       in_finish_n = 1'b1;
    logic [3:0] in_key = 4'd0;
    logic       in_kl_closed = 1'b0;
    logic       in_kl_error = 1'b0;
    logic       ou_kl_acc;
    logic       ou_kl_start;
    logic       ou_kl_finish;
    logic [3:0] ou_kl_key;
    logic [2:0] ou_digit_count;
    logic [1:0] ou_fail_count;
    logic       ou_busy;
    logic       ou_locked_out;
    logic       ou_bad_digit;

    keylock_sequencer dut (
        .clock          (clock),
        .in_reset_n     (in_reset_n),
        .in_acc_n       (in_acc_n),
        .in_start_n     (in_start_n),
        .in_finish_n    (in_finish_n),
        .in_key         (in_key),
        .in_kl_closed   (in_kl_closed),
        .in_kl_error    (in_kl_error),
        .ou_kl_acc      (ou_kl_acc),
        .ou_kl_start    (ou_kl_start),
        .ou_kl_finish   (ou_kl_finish),
        .ou_kl_key      (ou_kl_key),
        .ou_digit_count (ou_digit_count),
        .ou_fail_count  (ou_fail_count),
        .ou_busy        (ou_busy),
        .ou_locked_out  (ou_locked_out),
        .ou_bad_digit   (ou_bad_digit)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // observed (monitor) and expected (model) event counts
    // index 0 = acc, 1 = start, 2 = finish
    int n_p[3] = '{default: 0};
    int e_p[3] = '{default: 0};
    int n_bad = 0;
    int e_bad = 0;
    int n_lock = 0;
    int e_lock = 0;
    int m_digits = 0;
    int m_fails = 0;
    int m_key = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    string nm[3] = '{"acc", "start", "fin"};
    logic [2:0] prev_p = 3'b111;
    int run[3] = '{default: 0};
    int bad_run = 0;
    int lock_run = 0;

    always @(negedge clock) begin : mon
        logic [2:0] p;
        p = {ou_kl_finish, ou_kl_start, ou_kl_acc};
        if (!in_reset_n) begin
            prev_p   = 3'b111;
            run      = '{0, 0, 0};
            bad_run  = 0;
            lock_run = 0;
        end else begin
            if (p != 3'b111)
                chk("one_low", $countones(~p), 1);
            for (int i = 0; i < 3; i++) begin
                if (!p[i]) begin
                    if (prev_p[i]) n_p[i]++;
                    run[i]++;
                end else if (run[i] > 0) begin
                    chk({nm[i], "_width"}, run[i], PW);
                    run[i] = 0;
                end
            end
            prev_p = p;
            if (ou_bad_digit) begin
                if (bad_run == 0) n_bad++;
                bad_run++;
            end else if (bad_run > 0) begin
                chk("bad_width", bad_run, 1);
                bad_run = 0;
            end
            if (ou_locked_out) begin
                lock_run++;
            end else if (lock_run > 0) begin
                chk("lock_width", lock_run, LK);
                n_lock++;
                lock_run = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Keylock rules at the level of whole button presses.
    task automatic model(input logic [2:0] m, input int k,
                         input bit err, input bit closed);
        if (m[2]) begin
            if (m_digits == 5) begin
                e_p[2]++;
                m_digits = 0;
                if (err) begin
                    m_fails++;
                    if (m_fails == MF) begin
                        e_lock++;
                        m_fails = 0;
                    end
                end else begin
                    m_fails = 0;
                end
            end
        end else if (m[0]) begin
            if (k > 9) e_bad++;
            else if (m_digits < 5) begin
                e_p[0]++;
                m_digits++;
                m_key = k;
            end
        end else if (m[1]) begin
            if (m_digits == 0 && !closed) e_p[1]++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ou_busy && n < 300) begin
            cyc(1);
            n++;
        end
        chk("idle_wait", ou_busy, 0);
        cyc(2);
    endtask

    task automatic check_state();
        chk("n_acc", n_p[0], e_p[0]);
        chk("n_start", n_p[1], e_p[1]);
        chk("n_fin", n_p[2], e_p[2]);
        chk("n_bad", n_bad, e_bad);
        chk("n_lock", n_lock, e_lock);
        chk("digits", ou_digit_count, m_digits);
        chk("fails", ou_fail_count, m_fails);
        chk("key", ou_kl_key, m_key);
    endtask

    task automatic op(input logic [2:0] m, input int k,
                      input bit err, input bit closed);
        int lk0;
        lk0 = e_lock;
        model(m, k, err, closed);
        in_key = 4'(k);
        in_kl_error = err;
        in_kl_closed = closed;
        {in_finish_n, in_start_n, in_acc_n} = ~m;
        cyc(12);
        {in_finish_n, in_start_n, in_acc_n} = 3'b111;
        cyc(12);
        if (e_lock != lk0) begin
            chk("locked", ou_locked_out, 1);
            in_key = 4'd1;
            {in_finish_n, in_start_n, in_acc_n} = 3'b000;
            cyc(12);
            {in_finish_n, in_start_n, in_acc_n} = 3'b111;
            cyc(12);
        end
        wait_idle();
        check_state();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_acc"}, ou_kl_acc, 1);
        chk({tag, "_start"}, ou_kl_start, 1);
        chk({tag, "_fin"}, ou_kl_finish, 1);
        chk({tag, "_key"}, ou_kl_key, 0);
        chk({tag, "_digits"}, ou_digit_count, 0);
        chk({tag, "_fails"}, ou_fail_count, 0);
        chk({tag, "_busy"}, ou_busy, 0);
        chk({tag, "_lock"}, ou_locked_out, 0);
        chk({tag, "_bad"}, ou_bad_digit, 0);
    endtask

    int digs[5] = '{3, 0, 7, 9, 4};

    initial begin
        int n;
        logic [2:0] m;
        int r;
        #1 in_reset_n = 1'b0;
        #1 chk_reset("rst");
        cyc(3);
        in_reset_n = 1'b1;
        cyc(3);

        // bounce on acc, then a clean hold with digit 3
        in_key = 4'd3;
        for (int i = 0; i < 10; i++) begin
            in_acc_n = i[0];
            cyc(1);
        end
        in_acc_n = 1'b0;
        cyc(12);
        in_acc_n = 1'b1;
        cyc(12);
        wait_idle();
        model(3'b001, 3, 1'b0, 1'b0);
        check_state();

        // rest of 3,0,7,9,4 then a good result
        for (int i = 1; i < 5; i++) op(3'b001, digs[i], 1'b0, 1'b0);
        op(3'b100, 0, 1'b0, 1'b0);

        // three failed entries lead to lockout
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 5; i++) op(3'b001, digs[i], 1'b1, 1'b0);
            op(3'b100, 0, 1'b1, 1'b0);
        end

        // bad digit, then early finish is ignored
        op(3'b001, 12, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) op(3'b001, i + 1, 1'b0, 1'b0);
        op(3'b100, 0, 1'b0, 1'b0);
        op(3'b001, 8, 1'b0, 1'b0);

        // acc and finish together with 5 digits: finish wins
        op(3'b101, 5, 1'b0, 1'b0);
        op(3'b010, 0, 1'b0, 1'b1);
        op(3'b010, 0, 1'b0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            m = (r < 6) ? 3'b001 : (r < 8) ? 3'b100 :
                (r == 8) ? 3'b010 : 3'b101;
            op(m, int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
        end

        // reset in the middle of a finish pulse
        while (m_digits < 5) op(3'b001, 2, 1'b0, 1'b0);
        in_kl_error = 1'b0;
        in_finish_n = 1'b0;
        n = 0;
        while (ou_kl_finish !== 1'b0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("fin_seen", ou_kl_finish, 0);
        e_p[2]++;
        @(posedge clock);
        #2 in_reset_n = 1'b0;
        #1 chk_reset("midrst");
        in_finish_n = 1'b1;
        cyc(3);
        in_reset_n = 1'b1;
        m_digits = 0;
        m_fails = 0;
        m_key = 0;
        cyc(30);
        check_state();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
